letreiro_param: RTL

Parametrised scrolling LED-matrix marquee. It replaces the fixed 5×7 shift-register marquee with a writable message memory, a configurable matrix size and internal scan/step dividers. Four modes are provided: freeze, scroll left, scroll right and blink. It sits between the board switches and a row-scanned LED matrix, and drives one row at a time from a tear-free frame buffer.

---
 rtl/letreiro_param.sv | 136 +++++++++++++
 1 files changed

// File: rtl/letreiro_param.sv
// Scrolling LED-matrix marquee: writable message memory, row-scan and step dividers, tear-free frame buffer.
// Latency: first row lit SCAN_DIV cycles after reset; LETREIRO_DEADTIME_EN adds a one-cycle blank per row change.
// Backpressure: none; writes are accepted every cycle and out-of-range addresses are dropped.
module letreiro_param #(
  parameter int ROWS      = 5,
  parameter int COLS      = 7,
  parameter int MSG_LEN   = 32,
  parameter int SCAN_DIV  = 2000,
  parameter int SHIFT_DIV = 2_500_000,
  parameter int AW        = $clog2(MSG_LEN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ch0,
  input  logic            ch1,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [ROWS-1:0] wr_data,
  output logic [ROWS-1:0] L,
  output logic [COLS-1:0] C,
  output logic [AW-1:0]   offset,
  output logic            rele
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int STW = $clog2(SHIFT_DIV);
  localparam int RW  = $clog2(ROWS);

  logic [SCW-1:0]  sc;
  logic [STW-1:0]  st;
  logic [RW-1:0]   r;
  logic [RW-1:0]   r_nxt;
  logic            scan_tick;
  logic            step_tick;
  logic            frame_start;
  logic            bl;
  logic [1:0]      mode;
  logic [ROWS-1:0] mem      [MSG_LEN];
  logic [ROWS-1:0] frame    [COLS];
  logic [ROWS-1:0] load_col [COLS];
  logic [COLS-1:0] row_drv;

  assign mode        = {ch1, ch0};
  assign scan_tick   = (sc == SCW'(SCAN_DIV - 1));
  assign step_tick   = (st == STW'(SHIFT_DIV - 1));
  assign r_nxt       = (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
  assign frame_start = scan_tick && (r_nxt == '0);

  // Message column shown at C[c] is (offset + c) wrapped at MSG_LEN.
  for (genvar gc = 0; gc < COLS; gc++) begin : g_col
    logic [AW:0]   sum;
    logic [AW-1:0] idx;
    assign sum           = {1'b0, offset} + (AW+1)'(gc);
    assign idx           = (sum >= (AW+1)'(MSG_LEN)) ? AW'(sum - (AW+1)'(MSG_LEN)) : AW'(sum);
    assign load_col[gc]  = mem[idx];
`ifdef LETREIRO_DEADTIME_EN
    assign row_drv[gc]   = frame[gc][r];
`else
    // Row 0 of a new frame is driven straight from the columns being loaded.
    assign row_drv[gc]   = frame_start ? load_col[gc][r_nxt] : frame[gc][r_nxt];
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc <= '0;
      st <= '0;
      r  <= RW'(ROWS - 1);
    end else begin
      sc <= scan_tick ? '0 : sc + 1'b1;
      st <= step_tick ? '0 : st + 1'b1;
      if (scan_tick) r <= r_nxt;
    end
  end

  // A write landing on a reload edge is seen by the following frame only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= '0;
      for (int c = 0; c < COLS; c++) frame[c] <= '0;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN))) mem[wr_addr] <= wr_data;
      if (frame_start)
        for (int c = 0; c < COLS; c++) frame[c] <= load_col[c];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      offset <= '0;
      bl     <= 1'b0;
      rele   <= 1'b0;
    end else if (step_tick) begin
      rele <= ~rele;
      bl   <= (mode == 2'b11) ? ~bl : 1'b0;
      case (mode)
        2'b01:   offset <= (offset == AW'(MSG_LEN - 1)) ? '0 : offset + 1'b1;
        2'b10:   offset <= (offset == '0) ? AW'(MSG_LEN - 1) : offset - 1'b1;
        default: offset <= offset;
      endcase
    end
  end

`ifdef LETREIRO_DEADTIME_EN
  logic dt;

  // Blank for the scan_tick cycle, then light the already-advanced row.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      L  <= '0;
      C  <= '0;
      dt <= 1'b0;
    end else begin
      dt <= scan_tick;
      if (scan_tick) begin
        L <= '0;
        C <= '0;
      end else if (dt) begin
        L <= ROWS'(1) << r;
        C <= row_drv & {COLS{~bl}};
      end
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      L <= '0;
      C <= '0;
    end else if (scan_tick) begin
      L <= ROWS'(1) << r_nxt;
      C <= row_drv & {COLS{~bl}};
    end
  end
`endif

endmodule
